i2c_target_rx: RTL and testbench

- Write-only I2C target (responder) for the OLED/sigrok I2C bus; it is the receiving end of the bus driven by the SCL/SDA timing generator.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- Deserialises data bytes and presents them with a one-cycle valid strobe.
- Serves as the bench-side OLED emulator and as an on-chip capture point for logic-analyser loopback.

---
 rtl/i2c_target_rx_if.sv | 23 ++
 rtl/i2c_target_rx.sv | 186 ++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_rx_if.sv
// Bus-side bundle for the write-only I2C target: pin inputs plus the receive/event outputs.
// master = bench or SCL/SDA generator side, slave = the target itself.
interface i2c_target_rx_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport master (
        output scl, sda_in,
        input  sda_oe, rx_data, rx_valid, rx_first, start_det, stop_det, busy
    );

    modport slave (
        input  scl, sda_in,
        output sda_oe, rx_data, rx_valid, rx_first, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address ACK, byte strobe.
// Optional glitch filter on both lines when I2C_GLITCH_FILTER_EN is defined.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address byte
// ADDR_ACK | driving ACK for our address
// DATA     | shifting in a data byte
// DATA_ACK | driving ACK for a data byte
// IGNORE   | not addressed (or read request); wait for START/STOP
module i2c_target_rx #(
    parameter logic [6:0] ADDR     = 7'h3C,
    parameter int         FILT_LEN = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    i2c_target_rx_if.slave bus
);

    if (FILT_LEN < 1) begin : g_filt_len_check
        $error("FILT_LEN must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR_S, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s;
    logic       scl_d, sda_d;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic       first_q;
    logic       pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_flt, sda_flt;

    // Output flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
        end else begin
            if (scl_sync[1] == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
                scl_flt <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + CW'(1);
            end

            if (sda_sync[1] == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
                sda_flt <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + CW'(1);
            end
        end
    end

    assign scl_s = scl_flt;
    assign sda_s = sda_flt;
`else
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_q       <= '0;
            first_q       <= 1'b0;
            pend_q        <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.rx_first  <= 1'b0;
            bus.start_det <= 1'b0;
            bus.stop_det  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.rx_first  <= 1'b0;
            bus.start_det <= 1'b0;
            bus.stop_det  <= 1'b0;

            if (start_ev) begin
                state         <= ADDR_S;
                bit_cnt       <= '0;
                shift_q       <= '0;
                first_q       <= 1'b1;
                pend_q        <= 1'b0;
                bus.sda_oe    <= 1'b0;
                bus.start_det <= 1'b1;
                bus.busy      <= 1'b1;
            end else if (stop_ev) begin
                state        <= IDLE;
                pend_q       <= 1'b0;
                bus.sda_oe   <= 1'b0;
                bus.stop_det <= 1'b1;
                bus.busy     <= 1'b0;
            end else begin
                // Strobe one cycle after the 8th data bit lands in the shifter.
                if (pend_q) begin
                    bus.rx_data  <= shift_q;
                    bus.rx_valid <= 1'b1;
                    bus.rx_first <= first_q;
                    first_q      <= 1'b0;
                    pend_q       <= 1'b0;
                end

                case (state)
                    ADDR_S: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_q[7:1] == ADDR && !shift_q[0]) begin
                                bus.sda_oe <= 1'b1;
                                state      <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) pend_q <= 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bus.sda_oe <= 1'b1;
                            state      <= DATA_ACK;
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            bus.sda_oe <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, table vectors, corner sequences and randomized transfers.
module tb_i2c_target_rx;
    localparam int         Q        = 8;
    localparam logic [6:0] TGT_ADDR = 7'h3C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    i2c_target_rx_if bus ();
    assign bus.scl    = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_target_rx #(.ADDR(TGT_ADDR), .FILT_LEN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_strobe = 0, n_start = 0, n_stop = 0, n_oe = 0;
    logic [7:0] st_data  [0:255];
    logic       st_first [0:255];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            st_data[n_strobe & 255]  <= bus.rx_data;
            st_first[n_strobe & 255] <= bus.rx_first;
            n_strobe <= n_strobe + 1;
        end
        if (bus.start_det) n_start <= n_start + 1;
        if (bus.stop_det)  n_stop  <= n_stop + 1;
        if (bus.sda_oe)    n_oe    <= n_oe + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; q_wait();
        scl_drv = 1'b1; q_wait();
        sda_drv = 1'b0; q_wait();
        scl_drv = 1'b0; q_wait();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; q_wait();
        scl_drv = 1'b1; q_wait();
        sda_drv = 1'b1; q_wait(); q_wait();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; q_wait();
        scl_drv = 1'b1; q_wait(); q_wait();
        scl_drv = 1'b0; q_wait();
    endtask

    task automatic ack_slot(output logic acked);
        sda_drv = 1'b1; q_wait();
        scl_drv = 1'b1; q_wait();
        acked = (bus.sda_in == 1'b0);
        q_wait();
        scl_drv = 1'b0; q_wait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(acked);
    endtask

    // 2-clk SCL low pulse inside the high phase of bit 4.
    task automatic send_byte_glitch(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                sda_drv = b[i]; q_wait();
                scl_drv = 1'b1; repeat (3) @(negedge clk);
                scl_drv = 1'b0; repeat (2) @(negedge clk);
                scl_drv = 1'b1; repeat (2 * Q - 5) @(negedge clk);
                scl_drv = 1'b0; q_wait();
            end else begin
                send_bit(b[i]);
            end
        end
        ack_slot(acked);
    endtask

    // Reference: ACK iff address byte is our address with write bit; every data byte then strobed.
    function automatic bit model_ack(input logic [7:0] ab);
        return (ab == {TGT_ADDR, 1'b0});
    endfunction

    task automatic xfer(input string tag, input logic [7:0] ab, input int nd,
                        input logic [31:0] dw, input bit exp_ack, input int exp_n);
        int   bs, bst, bsp, boe;
        logic a;
        logic [7:0] d;
        bs = n_strobe; bst = n_start; bsp = n_stop; boe = n_oe;
        i2c_start();
        send_byte(ab, a);
        check({tag, ".addr_ack"}, 32'(a), 32'(exp_ack));
        for (int i = 0; i < nd; i++) begin
            d = dw[31 - 8 * i -: 8];
            send_byte(d, a);
            check({tag, ".data_ack"}, 32'(a), 32'(exp_ack));
        end
        check({tag, ".busy_mid"}, 32'(bus.busy), 32'd1);
        i2c_stop();
        #1;
        check({tag, ".n_strobe"}, 32'(n_strobe - bs), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            d = dw[31 - 8 * i -: 8];
            check({tag, ".rx_data"}, 32'(st_data[(bs + i) & 255]), 32'(d));
            check({tag, ".rx_first"}, 32'(st_first[(bs + i) & 255]), 32'(i == 0));
        end
        check({tag, ".n_start"}, 32'(n_start - bst), 32'd1);
        check({tag, ".n_stop"}, 32'(n_stop - bsp), 32'd1);
        check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        if (!exp_ack) check({tag, ".no_oe"}, 32'(n_oe - boe), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  ab;
        int          nd;
        logic [31:0] dw;
        bit          exp_ack;
        int          exp_n;
    } vec_t;

    vec_t vecs [5];

    task automatic check_reset_outputs(input string tag);
        check({tag, ".sda_oe"},    32'(bus.sda_oe),    32'd0);
        check({tag, ".rx_data"},   32'(bus.rx_data),   32'd0);
        check({tag, ".rx_valid"},  32'(bus.rx_valid),  32'd0);
        check({tag, ".rx_first"},  32'(bus.rx_first),  32'd0);
        check({tag, ".start_det"}, 32'(bus.start_det), 32'd0);
        check({tag, ".stop_det"},  32'(bus.stop_det),  32'd0);
        check({tag, ".busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bs, bst, bsp;
        logic a;
        logic [7:0] ab, glitch_exp;
        int   nd;
        logic [31:0] dw;
        bit   ea;

        vecs[0] = '{"write",   8'h78, 2, 32'h00AF_0000, 1'b1, 2};
        vecs[1] = '{"wrongad", 8'h7A, 1, 32'h5500_0000, 1'b0, 0};
        vecs[2] = '{"read",    8'h79, 1, 32'h5500_0000, 1'b0, 0};
        vecs[3] = '{"three",   8'h78, 3, 32'hFF01_8000, 1'b1, 3};
        vecs[4] = '{"addronly",8'h78, 0, 32'h0000_0000, 1'b1, 0};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst0_rel");

        for (int v = 0; v < 5; v++)
            xfer(vecs[v].name, vecs[v].ab, vecs[v].nd, vecs[v].dw, vecs[v].exp_ack, vecs[v].exp_n);

        // Repeated START after a partial byte: partial discarded.
        bs = n_strobe; bst = n_start; bsp = n_stop;
        i2c_start();
        send_byte(8'h78, a);
        check("rs.addr1_ack", 32'(a), 32'd1);
        for (int i = 7; i >= 4; i--) send_bit(i[0]);
        i2c_start();
        send_byte(8'h78, a);
        check("rs.addr2_ack", 32'(a), 32'd1);
        send_byte(8'h12, a);
        check("rs.data_ack", 32'(a), 32'd1);
        i2c_stop();
        #1;
        check("rs.n_strobe", 32'(n_strobe - bs), 32'd1);
        check("rs.rx_data", 32'(st_data[bs & 255]), 32'h12);
        check("rs.rx_first", 32'(st_first[bs & 255]), 32'd1);
        check("rs.n_start", 32'(n_start - bst), 32'd2);
        check("rs.n_stop", 32'(n_stop - bsp), 32'd1);

        // Reset while driving the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'h78 >> i) & 1) != 0);
        check("rst.oe_before", 32'(bus.sda_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        sda_drv = 1'b1;
        scl_drv = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst1_rel");
        xfer("post_rst", 8'h78, 1, 32'h5A00_0000, 1'b1, 1);

        // Randomized transfers against the reference model.
        for (int t = 0; t < 20; t++) begin
            ab = ($urandom_range(0, 1) != 0) ? 8'h78 : 8'($urandom);
            nd = $urandom_range(0, 3);
            dw = $urandom;
            ea = model_ack(ab);
            xfer("rand", ab, nd, dw, ea, ea ? nd : 0);
        end

        // SCL glitch mid-byte: filtered build keeps the byte, plain build sees an extra bit.
`ifdef I2C_GLITCH_FILTER_EN
        glitch_exp = 8'hA5;
`else
        glitch_exp = 8'hA2;
`endif
        bs = n_strobe;
        i2c_start();
        send_byte(8'h78, a);
        check("gl.addr_ack", 32'(a), 32'd1);
        send_byte_glitch(8'hA5, a);
        i2c_stop();
        #1;
        check("gl.n_strobe", 32'(n_strobe - bs), 32'd1);
        check("gl.rx_data", 32'(st_data[bs & 255]), 32'(glitch_exp));
        check("gl.rx_first", 32'(st_first[bs & 255]), 32'd1);
        check("gl.busy_end", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
